// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [7:0] CMD_ALU_DEFAULT = 8'hCC;
  localparam int         ALU_FUN_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_A    = 3'd1,
    S_GET_B    = 3'd2,
    S_GET_FUN  = 3'd3,
    S_ALU_WAIT = 3'd4,
    S_SEND_LO  = 3'd5,
    S_SEND_HI  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Inter-byte timeout down-counter for the ALU command sequencer.
// Only instantiated when ALU_SEQ_TIMEOUT_EN is defined.
// clr reloads the count; each enabled cycle decrements it; expire flags the
// enabled cycle that is the CYC-1'th cycle since the clearing byte (the
// clearing cycle itself counts as the first of the CYC cycles).
module seq_timeout_cnt #(
  parameter int CYC = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int                CNT_W = (CYC > 2) ? $clog2(CYC - 1) : 1;
  localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(CYC - 2);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == '0);

  // Reload on clear, otherwise count down while enabled and stop at zero.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-level command controller: parses {CMD, A, B, FUN} frames from the RX
// stream, fires the shared ALU for one cycle, and writes the 16-bit result to
// the TX FIFO as two bytes, LSB first.
// Optional inter-byte timeout: define ALU_SEQ_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the command byte, other bytes discarded
// S_GET_A    | next RX byte is operand A
// S_GET_B    | next RX byte is operand B
// S_GET_FUN  | next RX byte carries the function code, then fire the ALU
// S_ALU_WAIT | ALU enabled, waiting for its valid result
// S_SEND_LO  | write result LSB when the FIFO has room
// S_SEND_HI  | write result MSB when the FIFO has room
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                RES_W       = 16,
  parameter logic [DATA_W-1:0] CMD_ALU     = CMD_ALU_DEFAULT,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [RES_W-1:0]     ALU_OUT,
  input  logic                 OUT_VALID,
  input  logic                 FIFO_FULL,
  output logic [DATA_W-1:0]    ALU_A,
  output logic [DATA_W-1:0]    ALU_B,
  output logic [ALU_FUN_W-1:0] ALU_FUN,
  output logic                 ALU_EN,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 BUSY,
  output logic                 FRAME_ERR
);

  if ((RES_W != 2 * DATA_W) || (TIMEOUT_CYC < 2)) begin : g_bad_params
    $error("alu_cmd_sequencer: RES_W must equal 2*DATA_W and TIMEOUT_CYC must be >= 2");
  end

  seq_state_e       state;
  logic [RES_W-1:0] result;
  logic             in_frame;
  logic             rx_accept;
  logic             timeout;

  assign in_frame  = (state == S_GET_A) || (state == S_GET_B) || (state == S_GET_FUN);
  assign rx_accept = RX_D_VLD && (in_frame || ((state == S_IDLE) && (RX_P_DATA == CMD_ALU)));

`ifdef ALU_SEQ_TIMEOUT_EN
  logic cnt_en;

  assign cnt_en = in_frame && !rx_accept;

  seq_timeout_cnt #(
    .CYC (TIMEOUT_CYC)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (rx_accept),
    .en     (cnt_en),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // The write strobe is gated by the live FIFO_FULL so it can never coincide
  // with a full FIFO, and by RST so a reset in a send state suppresses the write.
  assign TX_D_VLD  = RST && !FIFO_FULL && ((state == S_SEND_LO) || (state == S_SEND_HI));
  assign TX_P_DATA = (state == S_SEND_HI) ? result[RES_W-1:DATA_W] :
                     (state == S_SEND_LO) ? result[DATA_W-1:0]     : '0;
  assign BUSY      = (state != S_IDLE);

  // Frame parser, ALU handshake and result capture.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      FRAME_ERR <= 1'b0;
      result    <= '0;
    end else begin
      ALU_EN    <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_accept) state <= S_GET_A;
        end
        S_GET_A: begin
          if (RX_D_VLD) begin
            ALU_A <= RX_P_DATA;
            state <= S_GET_B;
          end else if (timeout) begin
            FRAME_ERR <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_GET_B: begin
          if (RX_D_VLD) begin
            ALU_B <= RX_P_DATA;
            state <= S_GET_FUN;
          end else if (timeout) begin
            FRAME_ERR <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_GET_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[ALU_FUN_W-1:0];
            ALU_EN  <= 1'b1;
            state   <= S_ALU_WAIT;
          end else if (timeout) begin
            FRAME_ERR <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_ALU_WAIT: begin
          // A valid coinciding with our own enable belongs to an older operation.
          if (OUT_VALID && !ALU_EN) begin
            result <= ALU_OUT;
            state  <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (!FIFO_FULL) state <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (!FIFO_FULL) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Byte-level command controller that sequences the shared ALU from the receive path.
- Parses frames {CMD, A, B, FUN} from the receive data stream and pulses the ALU enable for exactly one cycle.
- Captures the registered 16-bit ALU result and pushes it as two bytes (LSB first) into the transmit FIFO.
- Sits between the RX data synchronizer, the ALU and the TX async FIFO, all in the reference-clock domain.

Parameters:
- DATA_W, 8: width of RX/TX bytes and of ALU operands A/B.
- RES_W, 16: ALU result width; must equal 2*DATA_W.
- CMD_ALU, 8'hCC: command byte that opens an ALU frame.
- TIMEOUT_CYC, 1024: inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: synchronous active-low reset.
- RX_P_DATA, input, DATA_W: received byte.
- RX_D_VLD, input, 1: one-cycle strobe; RX_P_DATA is valid in that cycle.
- ALU_OUT, input, RES_W: registered ALU result.
- OUT_VALID, input, 1: ALU result valid.
- FIFO_FULL, input, 1: TX FIFO cannot accept a write.
- ALU_A, output, DATA_W: operand A to the ALU.
- ALU_B, output, DATA_W: operand B to the ALU.
- ALU_FUN, output, 4: ALU function code.
- ALU_EN, output, 1: one-cycle ALU enable.
- TX_P_DATA, output, DATA_W: byte to the TX FIFO.
- TX_D_VLD, output, 1: TX FIFO write strobe.
- BUSY, output, 1: high in every state except IDLE.
- FRAME_ERR, output, 1: one-cycle pulse on timeout abort.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous and active-low. All state is sampled only on posedge CLK while RST=0.
- Reset values: every output is 0; state is IDLE.
- Reset mid-frame or mid-send: the frame is abandoned, no further TX writes occur, and the next cycle after release is IDLE.
- State machine: IDLE -> GET_A -> GET_B -> GET_FUN -> ALU_WAIT -> SEND_LO -> SEND_HI -> IDLE.
- IDLE:
  - On RX_D_VLD with RX_P_DATA == CMD_ALU, go to GET_A.
  - Any other byte is discarded and the block stays in IDLE.
- GET_A / GET_B: each RX_D_VLD latches RX_P_DATA into ALU_A / ALU_B and advances.
- GET_FUN:
  - On RX_D_VLD, latch RX_P_DATA[3:0] into ALU_FUN; upper bits are ignored.
  - Assert ALU_EN in the next cycle for exactly one cycle, then enter ALU_WAIT.
  - ALU_A, ALU_B and ALU_FUN hold their values until the next frame overwrites them.
- ALU_WAIT:
  - Capture ALU_OUT into an internal result register on the first cycle OUT_VALID=1; the ALU provides 1-cycle latency after ALU_EN.
  - Then go to SEND_LO.
- SEND_LO:
  - If FIFO_FULL=0, drive TX_P_DATA = result[7:0] with TX_D_VLD=1 for one cycle and go to SEND_HI.
  - If FIFO_FULL=1, hold the state with TX_D_VLD=0.
- SEND_HI: same rule with result[15:8], then go to IDLE.
- TX_D_VLD is never asserted while FIFO_FULL=1 in the same cycle.
- RX_D_VLD arriving in ALU_WAIT, SEND_LO or SEND_HI: the byte is dropped and the state is unaffected. BUSY lets upstream throttle.
- Back-to-back frames: a CMD byte accepted in the cycle IDLE is re-entered starts a new frame.
- Latency, with FIFO not full: last frame byte at cycle t -> ALU_EN at t+1 -> OUT_VALID at t+2 -> LSB write at t+3 -> MSB write at t+4.
- Arithmetic: no arithmetic in this block. Result bytes are pure slices of the 16-bit capture; ALU_FUN 4'hF is passed through unchanged.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted RX_D_VLD and increments each cycle in GET_A, GET_B and GET_FUN.
  - On reaching TIMEOUT_CYC-1, return to IDLE, pulse FRAME_ERR for one cycle, and do not assert ALU_EN.
- Undefined: no counter is built, FRAME_ERR is tied to 0, and a partial frame waits indefinitely.

Decomposition:
- Package alu_seq_pkg:
  - state enum seq_state_e.
  - localparam CMD_ALU_DEFAULT = 8'hCC.
  - ALU_FUN_W = 4.
- Sub-module seq_timeout_cnt:
  - Parameterised down-counter with clear, enable and expire outputs.
  - Instantiated only under ALU_SEQ_TIMEOUT_EN.

Test Plan:
1. Frame CC,0x12,0x34,0x0 (add), FIFO not full -> ALU_EN one cycle with A=0x12, B=0x34, FUN=0; TX writes 0x46 then 0x00 on consecutive cycles; BUSY returns to 0.
2. Frame CC,0xFF,0xFF,0x2 (mul) with FIFO_FULL=1 for 5 cycles in SEND_LO -> no TX_D_VLD while full; then 0x01 followed by 0xFE.
3. Junk bytes 0x55, 0xAA in IDLE, then frame CC,7,3,0xB (gt) -> junk ignored; TX writes 0x02, 0x00.
4. RST=0 asserted in SEND_HI (after LSB written) -> no MSB write; all outputs 0 next cycle; a new frame CC,5,5,0xA yields 0x01, 0x00.
5. RX_D_VLD bytes injected during ALU_WAIT/SEND -> bytes dropped; result bytes unchanged; next frame starts only on a fresh CC.
6. With ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: send CC,0x10 then silence -> FRAME_ERR pulses 16 cycles after the last byte; ALU_EN never asserted; state is IDLE.
